clock_time_counter: RTL and testbench
=====================================

Name: clock_time_counter

Overview:
- Timekeeping stage directly downstream of clk_gen.
- Consumes the 1 Hz, slow-set and fast-set strobes and maintains a BCD 24-hour hours/minutes/seconds count.
- Handles user time-setting from two held buttons, with press-and-hold acceleration.
- Outputs feed the display driver; o_time_stb flags each time change.

Parameters:
- HOLD_STROBES, 4, number of i_slow_set_stb pulses while a set button is held before switching to fast-rate increments (range 1..15).

Ports:
- i_clk  input  1  system clock, single clock domain.
- i_reset_n  input  1  synchronous active-low reset, sampled on rising i_clk.
- i_1hz_stb  input  1  one-cycle 1 Hz strobe from clk_gen.
- i_slow_set_stb  input  1  one-cycle slow set-rate strobe from clk_gen.
- i_fast_set_stb  input  1  one-cycle fast set-rate strobe from clk_gen.
- i_set_hours  input  1  hours-set button, level, already synchronized and debounced.
- i_set_minutes  input  1  minutes-set button, level, already synchronized and debounced.
- o_hours  output  6  BCD hours, [5:4] tens (0-2), [3:0] units.
- o_minutes  output  7  BCD minutes, [6:4] tens (0-5), [3:0] units.
- o_seconds  output  7  BCD seconds, same format as o_minutes.
- o_time_stb  output  1  one-cycle pulse the cycle after any time register changes.

Behaviour:
- Reset: synchronous, active-low. While i_reset_n=0 on a rising edge: o_hours=00, o_minutes=00, o_seconds=00, o_time_stb=0, FSM=IDLE, hold counter=0. Reset mid-set aborts the set and returns to IDLE.
- All outputs are registered. An event sampled in cycle N appears on the outputs in cycle N+1; o_time_stb pulses in cycle N+1 for one cycle.
- Run counting (FSM=IDLE only), on each i_1hz_stb:
  - seconds +1; 59 -> 00 with carry into minutes.
  - minutes 59 -> 00 with carry into hours.
  - hours 23 -> 00.
  - The full ripple completes in one cycle: 23:59:59 -> 00:00:00.
- BCD rules: units 9 -> 0 with a tens increment. Illegal BCD values are unreachable from reset.
- Set target: exactly one button asserted selects the target (hours or minutes). Both asserted is treated as none asserted.
- FSM states:
  - IDLE: normal counting. On a new target asserted -> PRESS.
  - PRESS: one cycle. Increment the target once, clear the hold counter -> SLOW.
  - SLOW: increment the target on each i_slow_set_stb and increment the hold counter. When the counter reaches HOLD_STROBES -> FAST.
  - FAST: increment the target on each i_fast_set_stb.
  - From SLOW or FAST: button released or both asserted -> IDLE the next cycle.
  - From SLOW or FAST: target changes to the other button -> PRESS with the new target.
- Set increments:
  - No carry out of the target field. Minutes wrap 59 -> 00 without touching hours; hours wrap 23 -> 00.
  - Each minutes set increment also clears seconds to 00. Hours increments leave seconds unchanged.
- While FSM != IDLE, i_1hz_stb is ignored: timekeeping is paused and strobes are not queued.
- Simultaneous events:
  - i_1hz_stb in the same cycle as the IDLE -> PRESS transition: the 1 Hz tick is dropped, the set increment is applied.
  - i_slow_set_stb and i_fast_set_stb coincident in FAST: only one increment.
  - i_fast_set_stb in SLOW: ignored.
- o_time_stb asserts after every run tick and every set increment, including a wrap to the same displayed value.

Optional Feature:
- Macro CLOCK_12H_EN.
- Defined:
  - Hours count in 12-hour format: 12, 01..11 (BCD).
  - Extra output port o_pm, 1 bit, reset 0; reset hours value is 12.
  - Run carry 11:59:59 -> 12:00:00 toggles o_pm.
  - Run carry 12:59:59 -> 01:00:00 leaves o_pm unchanged.
  - Hours set increment follows the same sequence and toggles o_pm on 11 -> 12.
- Undefined: 24-hour behaviour as above; no o_pm port.

Test Plan:
- Reset, then 61 i_1hz_stb pulses -> 00:01:01. o_time_stb pulses 61 times, each one cycle after its strobe.
- Force 23:59:59 via setting plus ticks, then one i_1hz_stb -> 00:00:00 next cycle with a single o_time_stb.
- Hold i_set_minutes from 00:00:30 -> 00:01:00 one cycle after PRESS. After HOLD_STROBES=4 slow strobes, minutes = 05 and slow strobes stop counting. Each fast strobe then adds 1; wrap 59 -> 00 leaves hours at 00.
- i_set_hours held with i_1hz_stb pulses injected -> seconds frozen. After 24 increments hours return to the start value; release -> counting resumes on the next 1 Hz strobe.
- Both buttons asserted while in SLOW -> IDLE next cycle, no increment. Reset asserted mid-FAST -> all fields 00 and IDLE on the next edge.
- With CLOCK_12H_EN: reset -> 12:00:00, o_pm=0. Set to 11:59:59 and tick -> 12:00:00, o_pm=1. Tick through 12:59:59 -> 01:00:00, o_pm=1.

Source files
------------

// File: rtl/clock_time_counter.sv
// Clock time counter: BCD HH:MM:SS timekeeping with hold-to-accelerate time setting.
// Optional CLOCK_12H_EN selects 12-hour hours (12, 01..11) plus an o_pm output.

module clock_time_counter #(
    parameter int unsigned HOLD_STROBES = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_1hz_stb,
    input  logic       i_slow_set_stb,
    input  logic       i_fast_set_stb,
    input  logic       i_set_hours,
    input  logic       i_set_minutes,
    output logic [5:0] o_hours,
    output logic [6:0] o_minutes,
    output logic [6:0] o_seconds,
    output logic       o_time_stb
`ifdef CLOCK_12H_EN
    ,
    output logic       o_pm
`endif
);

    // state    | meaning
    // ST_IDLE  | normal run counting on i_1hz_stb
    // ST_PRESS | single cycle: first increment of the newly selected target
    // ST_SLOW  | button held: increment on i_slow_set_stb, count hold strobes
    // ST_FAST  | button held long: increment on i_fast_set_stb
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_SLOW  = 2'd2,
        ST_FAST  = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_STROBES);

`ifdef CLOCK_12H_EN
    localparam logic [5:0] HOURS_RESET = 6'h12;
`else
    localparam logic [5:0] HOURS_RESET = 6'h00;
`endif

    state_t     state;
    logic       tgt_minutes;
    logic [3:0] hold_cnt;

    logic       req_hours;
    logic       req_minutes;
    logic       req_any;
    logic       req_other;

    logic [6:0] sec_inc;
    logic [6:0] min_inc;
    logic [5:0] hr_inc;
    logic       sec_wrap;
    logic       min_wrap;
    logic [3:0] hold_next;

    function automatic logic [6:0] inc_sexa(input logic [6:0] v);
        logic [6:0] r;
        if (v == 7'h59)
            r = 7'h00;
        else if (v[3:0] == 4'd9)
            r = {v[6:4] + 3'd1, 4'd0};
        else
            r = {v[6:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [5:0] inc_hours(input logic [5:0] v);
        logic [5:0] r;
`ifdef CLOCK_12H_EN
        if (v == 6'h12)
            r = 6'h01;
`else
        if (v == 6'h23)
            r = 6'h00;
`endif
        else if (v[3:0] == 4'd9)
            r = {v[5:4] + 2'd1, 4'd0};
        else
            r = {v[5:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Both buttons together count as no request.
    assign req_hours   = i_set_hours & ~i_set_minutes;
    assign req_minutes = i_set_minutes & ~i_set_hours;
    assign req_any     = req_hours | req_minutes;
    assign req_other   = tgt_minutes ? req_hours : req_minutes;

    assign sec_inc   = inc_sexa(o_seconds);
    assign min_inc   = inc_sexa(o_minutes);
    assign hr_inc    = inc_hours(o_hours);
    assign sec_wrap  = (o_seconds == 7'h59);
    assign min_wrap  = (o_minutes == 7'h59);
    assign hold_next = hold_cnt + 4'd1;

`ifdef CLOCK_12H_EN
    logic hr_to_noon;
    assign hr_to_noon = (o_hours == 6'h11);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            tgt_minutes <= 1'b0;
            hold_cnt    <= 4'd0;
            o_hours     <= HOURS_RESET;
            o_minutes   <= 7'h00;
            o_seconds   <= 7'h00;
            o_time_stb  <= 1'b0;
`ifdef CLOCK_12H_EN
            o_pm        <= 1'b0;
`endif
        end else begin
            o_time_stb <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A new set request wins over a coincident 1 Hz tick.
                    if (req_any) begin
                        state       <= ST_PRESS;
                        tgt_minutes <= req_minutes;
                    end else if (i_1hz_stb) begin
                        o_time_stb <= 1'b1;
                        o_seconds  <= sec_inc;
                        if (sec_wrap) begin
                            o_minutes <= min_inc;
                            if (min_wrap) begin
                                o_hours <= hr_inc;
`ifdef CLOCK_12H_EN
                                if (hr_to_noon)
                                    o_pm <= ~o_pm;
`endif
                            end
                        end
                    end
                end

                ST_PRESS: begin
                    o_time_stb <= 1'b1;
                    hold_cnt   <= 4'd0;
                    state      <= ST_SLOW;
                    if (tgt_minutes) begin
                        o_minutes <= min_inc;
                        o_seconds <= 7'h00;
                    end else begin
                        o_hours <= hr_inc;
`ifdef CLOCK_12H_EN
                        if (hr_to_noon)
                            o_pm <= ~o_pm;
`endif
                    end
                end

                ST_SLOW, ST_FAST: begin
                    if (!req_any) begin
                        state <= ST_IDLE;
                    end else if (req_other) begin
                        state       <= ST_PRESS;
                        tgt_minutes <= req_minutes;
                    end else if ((state == ST_SLOW) ? i_slow_set_stb : i_fast_set_stb) begin
                        o_time_stb <= 1'b1;
                        if (tgt_minutes) begin
                            o_minutes <= min_inc;
                            o_seconds <= 7'h00;
                        end else begin
                            o_hours <= hr_inc;
`ifdef CLOCK_12H_EN
                            if (hr_to_noon)
                                o_pm <= ~o_pm;
`endif
                        end
                        if (state == ST_SLOW) begin
                            hold_cnt <= hold_next;
                            if (hold_next == HOLD_LIM)
                                state <= ST_FAST;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed self-checking bench for clock_time_counter (24-hour build; 12-hour build when CLOCK_12H_EN).

module tb_clock_time_counter;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic       hz_stb;
    logic       slow_stb;
    logic       fast_stb;
    logic       set_h;
    logic       set_m;
    logic [5:0] hours;
    logic [6:0] minutes;
    logic [6:0] seconds;
    logic       time_stb;
`ifdef CLOCK_12H_EN
    logic       pm;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;

    clock_time_counter #(.HOLD_STROBES(HOLD)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_1hz_stb      (hz_stb),
        .i_slow_set_stb (slow_stb),
        .i_fast_set_stb (fast_stb),
        .i_set_hours    (set_h),
        .i_set_minutes  (set_m),
        .o_hours        (hours),
        .o_minutes      (minutes),
        .o_seconds      (seconds),
        .o_time_stb     (time_stb)
`ifdef CLOCK_12H_EN
        ,
        .o_pm           (pm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] bcd7(input int v);
        logic [6:0] r;
        r = {3'(v / 10), 4'(v % 10)};
        return r;
    endfunction

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        hz_stb = 1'b1;
        edge1();
        hz_stb = 1'b0;
    endtask

    // Press a button and apply n (>= HOLD+1) increments: press, HOLD slow, rest fast; then release.
    task automatic set_field(input bit is_min, input int n);
        set_m = is_min;
        set_h = !is_min;
        edge1();
        edge1();
        for (int i = 1; i < n; i++) begin
            if (i <= HOLD) slow_stb = 1'b1;
            else           fast_stb = 1'b1;
            edge1();
            slow_stb = 1'b0;
            fast_stb = 1'b0;
        end
        set_m = 1'b0;
        set_h = 1'b0;
        edge1();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        hz_stb = 1'b1;
        edge1();
        hz_stb = 1'b0;
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h00, 7'h00, 7'h00, 1'b0})
            $display("FAIL reset_values: got %h:%h:%h stb=%b expected 00:00:00 stb=0", hours, minutes, seconds, time_stb);
        else pass_cnt++;
        rst_n = 1'b1;
        edge1();
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h00, 7'h00, 7'h00, 1'b0})
            $display("FAIL reset_release: got %h:%h:%h stb=%b expected 00:00:00 stb=0", hours, minutes, seconds, time_stb);
        else pass_cnt++;
    endtask

    task automatic test_run_61();
        int stb_seen;
        stb_seen = 0;
        for (int i = 0; i < 61; i++) begin
            tick();
            if (time_stb === 1'b1) stb_seen++;
            edge1();
            if (time_stb !== 1'b0) stb_seen += 100;
        end
        total_cnt++;
        if (stb_seen !== 61)
            $display("FAIL run_stb_count: got %0d expected 61", stb_seen);
        else pass_cnt++;
        total_cnt++;
        if ({hours, minutes, seconds} !== {6'h00, 7'h01, 7'h01})
            $display("FAIL run_61: got %h:%h:%h expected 00:01:01", hours, minutes, seconds);
        else pass_cnt++;
    endtask

    task automatic test_set_minutes();
        rst_n = 1'b0;
        edge1();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        set_m  = 1'b1;
        hz_stb = 1'b1;
        edge1();
        hz_stb = 1'b0;
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h00, 7'h00, 7'h30, 1'b0})
            $display("FAIL press_tick_dropped: got %h:%h:%h stb=%b expected 00:00:30 stb=0", hours, minutes, seconds, time_stb);
        else pass_cnt++;
        edge1();
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h00, 7'h01, 7'h00, 1'b1})
            $display("FAIL press_increment: got %h:%h:%h stb=%b expected 00:01:00 stb=1", hours, minutes, seconds, time_stb);
        else pass_cnt++;
        fast_stb = 1'b1;
        edge1();
        fast_stb = 1'b0;
        total_cnt++;
        if ({minutes, time_stb} !== {7'h01, 1'b0})
            $display("FAIL fast_in_slow: got min=%h stb=%b expected min=01 stb=0", minutes, time_stb);
        else pass_cnt++;
        for (int i = 1; i <= HOLD; i++) begin
            slow_stb = 1'b1;
            edge1();
            slow_stb = 1'b0;
            total_cnt++;
            if ({minutes, time_stb} !== {bcd7(1 + i), 1'b1})
                $display("FAIL slow_step%0d: got min=%h stb=%b expected min=%h stb=1", i, minutes, time_stb, bcd7(1 + i));
            else pass_cnt++;
        end
        slow_stb = 1'b1;
        edge1();
        slow_stb = 1'b0;
        total_cnt++;
        if ({minutes, time_stb} !== {7'h05, 1'b0})
            $display("FAIL slow_in_fast: got min=%h stb=%b expected min=05 stb=0", minutes, time_stb);
        else pass_cnt++;
        fast_stb = 1'b1;
        edge1();
        total_cnt++;
        if ({minutes, time_stb} !== {7'h06, 1'b1})
            $display("FAIL fast_step: got min=%h stb=%b expected min=06 stb=1", minutes, time_stb);
        else pass_cnt++;
        slow_stb = 1'b1;
        edge1();
        slow_stb = 1'b0;
        fast_stb = 1'b0;
        total_cnt++;
        if (minutes !== 7'h07)
            $display("FAIL slow_fast_coincident: got min=%h expected 07", minutes);
        else pass_cnt++;
        for (int i = 0; i < 52; i++) begin
            fast_stb = 1'b1;
            edge1();
            fast_stb = 1'b0;
        end
        total_cnt++;
        if (minutes !== 7'h59)
            $display("FAIL fast_to_59: got min=%h expected 59", minutes);
        else pass_cnt++;
        fast_stb = 1'b1;
        edge1();
        fast_stb = 1'b0;
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h00, 7'h00, 7'h00, 1'b1})
            $display("FAIL set_min_wrap: got %h:%h:%h stb=%b expected 00:00:00 stb=1", hours, minutes, seconds, time_stb);
        else pass_cnt++;
        set_m = 1'b0;
        edge1();
        tick();
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h00, 7'h00, 7'h01, 1'b1})
            $display("FAIL resume_after_min_set: got %h:%h:%h stb=%b expected 00:00:01 stb=1", hours, minutes, seconds, time_stb);
        else pass_cnt++;
    endtask

    task automatic test_set_hours();
        set_h  = 1'b1;
        hz_stb = 1'b1;
        edge1();
        hz_stb = 1'b0;
        edge1();
        total_cnt++;
        if ({hours, seconds} !== {6'h01, 7'h01})
            $display("FAIL hours_press: got h=%h s=%h expected h=01 s=01", hours, seconds);
        else pass_cnt++;
        for (int i = 2; i <= 24; i++) begin
            tick();
            total_cnt++;
            if ({seconds, time_stb} !== {7'h01, 1'b0})
                $display("FAIL seconds_frozen%0d: got s=%h stb=%b expected s=01 stb=0", i, seconds, time_stb);
            else pass_cnt++;
            if (i <= HOLD + 1) slow_stb = 1'b1;
            else               fast_stb = 1'b1;
            edge1();
            slow_stb = 1'b0;
            fast_stb = 1'b0;
            total_cnt++;
            if ({hours, time_stb} !== {6'(bcd7(i % 24)), 1'b1})
                $display("FAIL hours_step%0d: got h=%h stb=%b expected h=%h stb=1", i, hours, time_stb, 6'(bcd7(i % 24)));
            else pass_cnt++;
        end
        set_h = 1'b0;
        edge1();
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h00, 7'h00, 7'h01, 1'b0})
            $display("FAIL hours_release: got %h:%h:%h stb=%b expected 00:00:01 stb=0", hours, minutes, seconds, time_stb);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({hours, minutes, seconds} !== {6'h00, 7'h00, 7'h02})
            $display("FAIL hours_resume: got %h:%h:%h expected 00:00:02", hours, minutes, seconds);
        else pass_cnt++;
    endtask

    task automatic test_full_wrap();
        set_field(1'b0, 23);
        set_field(1'b1, 59);
        for (int i = 0; i < 59; i++) tick();
        total_cnt++;
        if ({hours, minutes, seconds} !== {6'h23, 7'h59, 7'h59})
            $display("FAIL reach_235959: got %h:%h:%h expected 23:59:59", hours, minutes, seconds);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h00, 7'h00, 7'h00, 1'b1})
            $display("FAIL full_wrap: got %h:%h:%h stb=%b expected 00:00:00 stb=1", hours, minutes, seconds, time_stb);
        else pass_cnt++;
        edge1();
        total_cnt++;
        if (time_stb !== 1'b0)
            $display("FAIL wrap_single_stb: got stb=%b expected 0", time_stb);
        else pass_cnt++;
    endtask

    task automatic test_both_buttons();
        set_m = 1'b1;
        edge1();
        edge1();
        set_h    = 1'b1;
        slow_stb = 1'b1;
        edge1();
        slow_stb = 1'b0;
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h00, 7'h01, 7'h00, 1'b0})
            $display("FAIL both_no_inc: got %h:%h:%h stb=%b expected 00:01:00 stb=0", hours, minutes, seconds, time_stb);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h00, 7'h01, 7'h01, 1'b1})
            $display("FAIL both_idle_tick: got %h:%h:%h stb=%b expected 00:01:01 stb=1", hours, minutes, seconds, time_stb);
        else pass_cnt++;
        set_h = 1'b0;
        set_m = 1'b0;
        edge1();
        set_m = 1'b1;
        edge1();
        edge1();
        set_m = 1'b0;
        set_h = 1'b1;
        edge1();
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h00, 7'h02, 7'h00, 1'b0})
            $display("FAIL switch_repress: got %h:%h:%h stb=%b expected 00:02:00 stb=0", hours, minutes, seconds, time_stb);
        else pass_cnt++;
        edge1();
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h01, 7'h02, 7'h00, 1'b1})
            $display("FAIL switch_hours_inc: got %h:%h:%h stb=%b expected 01:02:00 stb=1", hours, minutes, seconds, time_stb);
        else pass_cnt++;
        set_h = 1'b0;
        edge1();
    endtask

    task automatic test_reset_mid_fast();
        set_m = 1'b1;
        edge1();
        edge1();
        for (int i = 0; i < HOLD; i++) begin
            slow_stb = 1'b1;
            edge1();
            slow_stb = 1'b0;
        end
        fast_stb = 1'b1;
        edge1();
        total_cnt++;
        if ({hours, minutes} !== {6'h01, 7'h08})
            $display("FAIL reach_fast: got h=%h m=%h expected h=01 m=08", hours, minutes);
        else pass_cnt++;
        rst_n = 1'b0;
        edge1();
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h00, 7'h00, 7'h00, 1'b0})
            $display("FAIL reset_mid_fast: got %h:%h:%h stb=%b expected 00:00:00 stb=0", hours, minutes, seconds, time_stb);
        else pass_cnt++;
        rst_n    = 1'b1;
        fast_stb = 1'b0;
        set_m    = 1'b0;
        edge1();
        tick();
        total_cnt++;
        if ({hours, minutes, seconds, time_stb} !== {6'h00, 7'h00, 7'h01, 1'b1})
            $display("FAIL idle_after_reset: got %h:%h:%h stb=%b expected 00:00:01 stb=1", hours, minutes, seconds, time_stb);
        else pass_cnt++;
    endtask

`ifdef CLOCK_12H_EN
    task automatic test_12h();
        rst_n = 1'b0;
        edge1();
        rst_n = 1'b1;
        total_cnt++;
        if ({hours, minutes, seconds, pm} !== {6'h12, 7'h00, 7'h00, 1'b0})
            $display("FAIL reset_12h: got %h:%h:%h pm=%b expected 12:00:00 pm=0", hours, minutes, seconds, pm);
        else pass_cnt++;
        set_field(1'b0, 11);
        set_field(1'b1, 59);
        for (int i = 0; i < 59; i++) tick();
        total_cnt++;
        if ({hours, minutes, seconds, pm} !== {6'h11, 7'h59, 7'h59, 1'b0})
            $display("FAIL reach_115959: got %h:%h:%h pm=%b expected 11:59:59 pm=0", hours, minutes, seconds, pm);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({hours, minutes, seconds, pm} !== {6'h12, 7'h00, 7'h00, 1'b1})
            $display("FAIL noon_carry: got %h:%h:%h pm=%b expected 12:00:00 pm=1", hours, minutes, seconds, pm);
        else pass_cnt++;
        set_field(1'b1, 59);
        for (int i = 0; i < 59; i++) tick();
        tick();
        total_cnt++;
        if ({hours, minutes, seconds, pm} !== {6'h01, 7'h00, 7'h00, 1'b1})
            $display("FAIL one_oclock_carry: got %h:%h:%h pm=%b expected 01:00:00 pm=1", hours, minutes, seconds, pm);
        else pass_cnt++;
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        hz_stb   = 1'b0;
        slow_stb = 1'b0;
        fast_stb = 1'b0;
        set_h    = 1'b0;
        set_m    = 1'b0;
        edge1();
`ifdef CLOCK_12H_EN
        test_12h();
`else
        test_reset();
        test_run_61();
        test_set_minutes();
        test_set_hours();
        test_full_wrap();
        test_both_buttons();
        test_reset_mid_fast();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
